seq_divider: RTL and testbench

Multi-cycle iterative divider that undoes what the 32-bit carry-lookahead adder does: it computes by repeated two's-complement subtraction (A + ~B + 1) instead of addition. It produces quotient and remainder for signed or unsigned operands, one quotient bit per clock. It sits beside the ALU in the KGP-RISC execute stage and serves the divide and modulo instructions through a start/done handshake. While it runs, the pipeline stalls on `busy`.

---
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider: quotient and remainder for signed or unsigned
// operands. Each iteration is one subtraction done as A + ~B + 1, one
// quotient bit per clock.
// Latency: done is high WIDTH+1 cycles after the accepting edge, or 1 cycle
// after it when the divisor is zero.
// Backpressure: start is sampled only in IDLE and is ignored while busy or
// during the done cycle. Results are held until the next accepted start.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, is_signed        request and operand mode, both sampled in IDLE
//   dividend, divisor       operands, captured with start
//   busy                    high from the accept edge until the done edge
//   done                    one-cycle pulse; results are valid in that cycle
//   quotient, remainder     registered results
//   div_by_zero             registered flag, set together with done
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH + 1)'(1);
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] prem;   // partial remainder; always < divisor, so WIDTH bits are enough
  logic [WIDTH-1:0] dvd;    // dividend magnitude, which turns into the quotient as it shifts
  logic [WIDTH-1:0] dvs;    // divisor magnitude
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             div_zero;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  always_comb begin
    div_zero = (divisor == '0);
    abs_dvd  = (is_signed && dividend[WIDTH-1]) ? negate(dividend) : dividend;
    abs_dvs  = (is_signed && divisor[WIDTH-1])  ? negate(divisor)  : divisor;
    // The 33-bit shifted remainder; trial is negative (top bit set) when shifted < dvs.
    shifted  = {prem, dvd[WIDTH-1]};
    trial    = shifted + ~{1'b0, dvs} + ONE_X;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prem        <= '0;
      dvd         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // On divide-by-zero the raw dividend is kept, because it becomes the remainder.
            dvd         <= div_zero ? dividend : abs_dvd;
            dvs         <= abs_dvs;
            neg_q       <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= is_signed && dividend[WIDTH-1];
            dz          <= div_zero;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= div_zero ? DONE : RUN;
          end
        end

        RUN: begin
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH-1:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end

        FIX: begin
          quotient  <= neg_q ? negate(dvd)  : dvd;
          remainder <= neg_r ? negate(prem) : prem;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end

        DONE: begin
          // Arriving from FIX, done is already high and this is the done cycle.
          // Arriving straight from IDLE (divisor zero), done is raised here first.
          if (!done) begin
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= dz;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;
  } res_t;

  res_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [31:0] q, input logic [31:0] r, input logic z);
    res_t x;
    x.quo = q; x.rem = r; x.dz = z;
    return x;
  endfunction

  // Reference for random vectors: truncating division, remainder follows dividend.
  function automatic res_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    res_t x;
    if (b == 0)
      x = mk(32'hFFFF_FFFF, a, 1'b1);
    else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      x = mk(32'h8000_0000, 32'h0, 1'b0);
    else if (sgn) begin
      x.quo = $signed(a) / $signed(b);
      x.rem = $signed(a) % $signed(b);
      x.dz  = 1'b0;
    end else
      x = mk(a / b, a % b, 1'b0);
    return x;
  endfunction

  // Drive a request at a falling edge, let the next rising edge (E0) accept it.
  task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input res_t exp);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done, checking busy on the way; repulse drives stray starts at
  // iterations 3 and 32 and in the done cycle.
  task automatic wait_done(input string tag, input int exp_lat, input bit repulse);
    int   n = 0;
    bit   got = 0;
    res_t e;
    while (n < 100 && !got) begin
      @(negedge clk); n++;
      start = 1'b0;
      if (done) got = 1;
      else begin
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        if (repulse && (n == 3 || n == 32)) begin
          start = 1'b1; is_signed = 1'b1;
          dividend = $urandom; divisor = $urandom_range(1, 50);
        end
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'(n), 32'(exp_lat + 1));
      return;
    end
    check({tag, "_latency"}, 32'(n - 1), 32'(exp_lat));
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_quotient"}, quotient, e.quo);
    check({tag, "_remainder"}, remainder, e.rem);
    check({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, e.dz});
    if (repulse) begin
      start = 1'b1; is_signed = 1'b0; dividend = 32'd999; divisor = 32'd3;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    check({tag, "_q_held"}, quotient, e.quo);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;

    // Reset state
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    start_op(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
    wait_done("u100_7", 33, 1'b0);

    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
    wait_done("s_m7_2", 33, 1'b0);
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0));
    wait_done("s_7_m2", 33, 1'b0);

    start_op(1'b0, 32'h0000_1234, 32'd0, mk(32'hFFFF_FFFF, 32'h0000_1234, 1'b1));
    wait_done("u_div0", 1, 1'b0);
    start_op(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
    wait_done("after_div0", 33, 1'b0);
    start_op(1'b1, 32'hFFFF_FF00, 32'd0, mk(32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1));
    wait_done("s_div0", 1, 1'b0);

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0));
    wait_done("s_min_m1", 33, 1'b0);
    start_op(1'b0, 32'hFFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0));
    wait_done("u_max_1", 33, 1'b0);
    start_op(1'b0, 32'd5, 32'd9, mk(32'd0, 32'd5, 1'b0));
    wait_done("u5_9", 33, 1'b0);

    // Stray starts while busy and during done must not disturb the result
    start_op(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
    wait_done("repulse", 33, 1'b1);

    // Reset in the middle of iteration 10
    start_op(1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
    for (int i = 0; i < 11; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start_op(1'b0, 32'd1000, 32'd10, mk(32'd100, 32'd0, 1'b0));
    wait_done("after_rst", 33, 1'b0);

    // Random operands against the reference model
    for (int k = 0; k < 10; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case (k % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 1000);
        2: b = 32'(-$signed(32'($urandom_range(1, 1000))));
        default: b = (k == 7) ? 32'd0 : {16'h0, 16'($urandom)};
      endcase
      start_op(sgn, a, b, model(sgn, a, b));
      wait_done("rand", (b == 0) ? 1 : 33, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
